// File: rtl/program_loader_pkg.sv
// Shared RISC-V core package: instruction field layout, immediate packing and unpacking,
// and the loader FSM state type.
package common;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } encoding_type;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_type;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // The B-type immediate is in halfword units, so inst[31] holds bit 11 and inst[7] holds bit 10.
    function automatic logic [31:0] immediate_extension(logic [31:0] instr, encoding_type enc);
        logic [31:0] res;
        res = '0;
        case (enc)
            I_TYPE: res = {{20{instr[31]}}, instr[31:20]};
            S_TYPE: res = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE: res = {{20{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8]};
            U_TYPE: res = {12'b0, instr[31:12]};
            J_TYPE: res = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic imm_in_range(logic [31:0] imm, encoding_type enc);
        logic ok;
        ok = 1'b0;
        case (enc)
            R_TYPE:                 ok = 1'b1;
            I_TYPE, S_TYPE, B_TYPE: ok = (imm[31:11] == '0) || (imm[31:11] == '1);
            U_TYPE:                 ok = (imm[31:20] == '0);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] instruction_encode(instruction_type fields, logic [31:0] imm,
                                                       encoding_type enc);
        logic [31:0] w;
        w = NOP_INSTR;
        case (enc)
            R_TYPE: w = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
            I_TYPE: w = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
            S_TYPE: w = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
            B_TYPE: w = {imm[11], imm[9:4], fields.rs2, fields.rs1, fields.funct3,
                         imm[3:0], imm[10], fields.opcode};
            U_TYPE: w = {imm[19:0], fields.rd, fields.opcode};
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/program_loader_encoder.sv
// Combinational instruction packer: produces the encoded word, or a NOP plus a reject flag.
module instr_encoder
    import common::*;
(
    input  instruction_type fields,
    input  logic [31:0]     imm,
    input  logic [2:0]      enc,
    output logic [31:0]     word,
    output logic            reject
);

    encoding_type enc_t;
    logic         enc_ok;

    assign enc_t  = encoding_type'(enc);
    assign enc_ok = (enc <= 3'd4);
    assign reject = !enc_ok || !imm_in_range(imm, enc_t);
    assign word   = reject ? NOP_INSTR : instruction_encode(fields, imm, enc_t);

endmodule

// File: rtl/program_loader.sv
// Streams encoded instructions into instruction memory at consecutive word addresses,
// using one registered encode stage with a held write request.
module program_loader
    import common::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_encoding,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_wr_en,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data
);

    loader_state_type  state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   accepted;
    instruction_type   fields;
    logic [31:0]       enc_word;
    logic              enc_reject;
    logic              wr_fire;
    logic              accept;

    assign fields = '{funct7: in_funct7, rs2: in_rs2, rs1: in_rs1, funct3: in_funct3,
                      rd: in_rd, opcode: in_opcode};

    instr_encoder u_enc (
        .fields (fields),
        .imm    (in_imm),
        .enc    (in_encoding),
        .word   (enc_word),
        .reject (enc_reject)
    );

    // A new accept may coincide with the previous write being taken.
    assign wr_fire  = mem_wr_en && mem_wr_ready;
    assign in_ready = (state == LOAD) && (accepted < len) && (!mem_wr_en || mem_wr_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            accepted    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base      <= base_addr;
                        len       <= length;
                        accepted  <= '0;
                        err_count <= '0;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (wr_fire)
                        mem_wr_en <= 1'b0;
                    if (accept) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= base + accepted[ADDR_W-1:0];
                        mem_wr_data <= enc_word;
                        accepted    <= accepted + (ADDR_W+1)'(1);
                        if (enc_reject && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                    if (accepted == len && (wr_fire || !mem_wr_en)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of encodings streamed in one load, plus
// backpressure/wrap, empty-load and mid-load reset sequences.
module tb_program_loader;
    import common::*;

    localparam int AW = 4;
    localparam int NV = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, in_ready, mem_wr_en;
    logic [7:0]    err_count;
    logic          in_valid = 1'b0;
    logic [2:0]    in_encoding = '0;
    logic [6:0]    in_opcode = '0;
    logic [4:0]    in_rd = '0;
    logic [2:0]    in_funct3 = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [6:0]    in_funct7 = '0;
    logic [31:0]   in_imm = '0;
    logic          mem_wr_ready = 1'b1;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  enc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] word;
        logic        rej;
    } vec_t;

    vec_t vecs[NV];

    program_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .err_count(err_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_encoding(in_encoding), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_encoding = v.enc; in_opcode = v.op; in_rd = v.rd; in_funct3 = v.f3;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_funct7 = v.f7; in_imm = v.imm;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        check({tag, " mem_wr_addr"}, 32'(mem_wr_addr), 32'd0);
        check({tag, " mem_wr_data"}, mem_wr_data, 32'd0);
    endtask

    initial begin
        int exp_err;

        vecs[0]  = '{I_TYPE, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5,         32'h00500093, 1'b0};
        vecs[1]  = '{R_TYPE, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'hDEADBEEF,  32'h002081B3, 1'b0};
        vecs[2]  = '{S_TYPE, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'd8,         32'h0020A423, 1'b0};
        vecs[3]  = '{B_TYPE, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'hFFFFFFFE,  32'hFE208EE3, 1'b0};
        vecs[4]  = '{I_TYPE, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd4096,      32'h00000013, 1'b1};
        vecs[5]  = '{J_TYPE, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'd8,         32'h00000013, 1'b1};
        vecs[6]  = '{U_TYPE, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00012345,  32'h123452B7, 1'b0};
        vecs[7]  = '{U_TYPE, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00100000,  32'h00000013, 1'b1};
        vecs[8]  = '{I_TYPE, 7'h13, 5'd1, 3'd0, 5'd2, 5'd0, 7'h00, 32'hFFFFF800,  32'h80010093, 1'b0};
        vecs[9]  = '{I_TYPE, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'h000007FF,  32'h7FF00093, 1'b0};
        vecs[10] = '{3'd6,   7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'd0,         32'h00000013, 1'b1};
        vecs[11] = '{S_TYPE, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'hFFFFF7FF,  32'h00000013, 1'b1};
        vecs[12] = '{B_TYPE, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'h00000800,  32'h00000013, 1'b1};
        vecs[13] = '{U_TYPE, 7'h17, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h000FFFFF,  32'hFFFFF017, 1'b0};
        vecs[14] = '{S_TYPE, 7'h23, 5'd0, 3'd2, 5'd6, 5'd5, 7'h00, 32'hFFFFFFFC,  32'hFE532E23, 1'b0};

        // Reset state
        tick; tick;
        check_all_zero("reset");
        reset_n = 1'b1;
        tick;
        check_all_zero("idle");

        // Table load: base 0, one word per cycle, with a stray start mid-load
        start = 1'b1; base_addr = 4'd0; length = 5'(NV);
        tick;
        start = 1'b0;
        check("table busy", 32'(busy), 32'd1);
        exp_err = 0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            if (i == 2) begin
                start = 1'b1; base_addr = 4'd9;
            end
            tick;
            start = 1'b0;
            if (vecs[i].rej) exp_err++;
            check($sformatf("vec%0d wr_en", i), 32'(mem_wr_en), 32'd1);
            check($sformatf("vec%0d addr", i), 32'(mem_wr_addr), 32'(i));
            check($sformatf("vec%0d data", i), mem_wr_data, vecs[i].word);
            check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(exp_err));
            if (i == 3)
                check("b_type round trip", immediate_extension(mem_wr_data, B_TYPE), 32'hFFFFFFFE);
        end
        in_valid = 1'b0;
        tick;
        check("table done", 32'(done), 32'd1);
        check("table busy in done", 32'(busy), 32'd0);
        check("table wr_en in done", 32'(mem_wr_en), 32'd0);
        check("table err final", 32'(err_count), 32'd6);
        tick;
        check("table done pulse", 32'(done), 32'd0);
        check("table err hold", 32'(err_count), 32'd6);

        // Empty load goes straight to DONE
        start = 1'b1; base_addr = 4'd3; length = 5'd0;
        tick;
        start = 1'b0;
        check("len0 done", 32'(done), 32'd1);
        check("len0 busy", 32'(busy), 32'd0);
        check("len0 err cleared", 32'(err_count), 32'd0);
        tick;
        check("len0 done pulse", 32'(done), 32'd0);

        // Backpressure and address wrap: base 15, length 2
        mem_wr_ready = 1'b0;
        start = 1'b1; base_addr = 4'd15; length = 5'd2;
        tick;
        start = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        tick;
        check("bp first en", 32'(mem_wr_en), 32'd1);
        check("bp first addr", 32'(mem_wr_addr), 32'd15);
        check("bp first data", mem_wr_data, 32'h00500093);
        drive(vecs[1]);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp stall%0d in_ready", k), 32'(in_ready), 32'd0);
            tick;
            check($sformatf("bp stall%0d en", k), 32'(mem_wr_en), 32'd1);
            check($sformatf("bp stall%0d addr", k), 32'(mem_wr_addr), 32'd15);
            check($sformatf("bp stall%0d data", k), mem_wr_data, 32'h00500093);
        end
        mem_wr_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check("bp second en", 32'(mem_wr_en), 32'd1);
        check("bp wrap addr", 32'(mem_wr_addr), 32'd0);
        check("bp second data", mem_wr_data, 32'h002081B3);
        tick;
        check("bp done", 32'(done), 32'd1);
        tick;

        // Reset with a write pending, then a clean reload
        mem_wr_ready = 1'b0;
        start = 1'b1; base_addr = 4'd3; length = 5'd4;
        tick;
        start = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check("pend en", 32'(mem_wr_en), 32'd1);
        check("pend addr", 32'(mem_wr_addr), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick;
        reset_n = 1'b1;
        mem_wr_ready = 1'b1;
        start = 1'b1; base_addr = 4'd7; length = 5'd1;
        tick;
        start = 1'b0;
        check("reload busy", 32'(busy), 32'd1);
        drive(vecs[6]);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check("reload addr", 32'(mem_wr_addr), 32'd7);
        check("reload data", mem_wr_data, 32'h123452B7);
        tick;
        check("reload done", 32'(done), 32'd1);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Sequential instruction encoder and loader for the RISC-V core. It accepts instruction field bundles over a valid/ready stream and packs them into 32-bit instruction words, placing immediates exactly as the shared package's `immediate_extension` expects to unpack them. It writes the words into instruction memory at consecutive word addresses. It sits between the bench/debug host and the instruction-memory write port.

## Interface
Parameters:
- `ADDR_W`, 8, word-address width of the instruction memory.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load of `length` words at `base_addr`. Sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address. Captured on `start`.
- `length`  in  ADDR_W+1  number of words to load. Captured on `start`.
- `busy`  out  1  high in LOAD.
- `done`  out  1  one-cycle pulse in DONE.
- `err_count`  out  8  saturating count of rejected instructions in the current load.
- `in_valid` / `in_ready`  in / out  1  input handshake.
- `in_encoding`  in  3  `encoding_type`.
- `in_opcode`, `in_rd`, `in_funct3`, `in_rs1`, `in_rs2`, `in_funct7`  in  7/5/3/5/5/7  instruction fields.
- `in_imm`  in  32  signed immediate. For B_TYPE it is the halfword-unit value.
- `mem_wr_en`  out  1  write request. Held until accepted.
- `mem_wr_ready`  in  1  memory accepts the write when `mem_wr_en && mem_wr_ready`.
- `mem_wr_addr`  out  ADDR_W  word address.
- `mem_wr_data`  out  32  encoded instruction.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE: on `start`, capture `base_addr`/`length` and clear `err_count`. Go to LOAD, or directly to DONE if `length==0`.
  - LOAD: accept instructions until `length` have been accepted and the last write has been accepted. Then go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
  - `start` is ignored outside IDLE.
- `in_ready = (state==LOAD) && (accepted < length) && (!mem_wr_en || mem_wr_ready)`.
- Encoding of the fields (`inst[31:0]`):
  - R_TYPE: `{funct7, rs2, rs1, funct3, rd, opcode}`. `in_imm` is ignored.
  - I_TYPE: `{imm[11:0], rs1, funct3, rd, opcode}`.
  - S_TYPE: `{imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}`.
  - B_TYPE: `funct7 = {imm[11], imm[9:4]}` and `rd = {imm[3:0], imm[10]}`, with `rs2`, `rs1`, `funct3` and `opcode` as given.
  - U_TYPE: `{imm[19:0], rd, opcode}`.
- Round-trip rule: for every in-range value, the package's `immediate_extension` applied to the encoded word returns `in_imm`.
- Range checks:
  - I, S and B: `in_imm` must lie in [-2048, 2047].
  - U: `in_imm` must lie in [0, 2^20-1].
- Rejection: J_TYPE, encodings 6–7, and out-of-range immediates are rejected.
  - The word written is `32'h00000013` (NOP).
  - `err_count` increments and saturates at 255.
  - The write address still advances.
- Write address = `base_addr + accepted_index`, modulo 2^ADDR_W (wrap-around allowed).
- Reset (any time, including mid-load):
  - State returns to IDLE and any pending write is dropped.
  - All outputs are 0.

## Timing
- Encoding happens in one registered stage. An instruction accepted at edge N drives `mem_wr_en`, `mem_wr_addr` and `mem_wr_data` from edge N to the edge where `mem_wr_ready` is high.
- While the memory backpressures, the write outputs stay stable and `in_ready` stays low.
- Throughput: 1 word/cycle when `mem_wr_ready` is constantly high.
- A new accept and the acceptance of the previous write may occur in the same cycle.
- DONE is entered the cycle after the final write is accepted. `done` is high for exactly one cycle. `busy` is low in DONE.
- `err_count` updates on the accept edge and holds its value until the next `start`.

## Structure
- Package `common` gains:
  - function `instruction_encode(instruction_type fields, logic [31:0] imm, encoding_type enc)` returning the packed word;
  - function `imm_in_range`;
  - constant `NOP_INSTR = 32'h00000013`;
  - the FSM state enum `loader_state_type`.
- One sub-module, `instr_encoder`: a combinational wrapper around the package functions that produces `word` and `reject`.
- The top level holds the FSM, the counters and the output register.

## Test plan
- I_TYPE: opcode 0010011, rd 1, rs1 0, funct3 0, imm 5, at `base_addr` 0 -> writes `0x00500093` at address 0.
- R_TYPE and S_TYPE back-to-back:
  - R_TYPE add x3,x1,x2 -> `0x002081B3` at address 0.
  - S_TYPE sw x2,8(x1) -> `0x0020A423` at address 1.
  - `done` pulses after the second write.
- B_TYPE beq x1,x2 with imm -2 -> `0xFE208EE3`. Applying `immediate_extension` to that word returns `0xFFFFFFFE`.
- Rejection: I_TYPE imm 4096, then a J_TYPE -> two NOPs (`0x00000013`) written and `err_count` = 2.
- Backpressure and wrap, with ADDR_W=4, base 15, length 2, and `mem_wr_ready` low for 3 cycles:
  - data and address stay stable throughout the stall;
  - `in_ready` stays low during the stall;
  - the writes land at addresses 15 and then 0.
- Reset mid-load: assert `reset_n` low with a write pending -> all outputs are 0 and `busy` is 0. A new `start` after reset loads correctly from its own `base_addr`.
